// File: rtl/payload_package.sv
// Shared payload definitions for the transaction source and the register-slice FIFO side.
package payload_package;

  localparam int PAYLOAD_ID_WIDTH   = 3;
  localparam int PAYLOAD_ADDR_WIDTH = 32;
  localparam int PAYLOAD_DATA_WIDTH = 32;

  typedef struct packed {
    logic [PAYLOAD_ID_WIDTH-1:0]   id;
    logic [PAYLOAD_ADDR_WIDTH-1:0] addr;
    logic [PAYLOAD_DATA_WIDTH-1:0] data;
  } payload_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } src_state_t;

endpackage

// File: rtl/payload_src.sv
// Burst initiator: emits len beats with incrementing ID/ADDR/DATA on a valid/ready channel.
// state | meaning
// IDLE  | waiting for start; inputs captured on start
// SEND  | beat on out_payload with dvalid=1, advancing on each accepted beat
// DONE  | single-cycle done pulse, beat_cnt holds the final count
module payload_src
  import payload_package::*;
#(
  parameter int ID_WIDTH    = PAYLOAD_ID_WIDTH,
  parameter int ADDR_WIDTH  = PAYLOAD_ADDR_WIDTH,
  parameter int DATA_WIDTH  = PAYLOAD_DATA_WIDTH,
  parameter int LEN_WIDTH   = 8,
  parameter int ADDR_STRIDE = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  len,
  input  logic [ID_WIDTH-1:0]   start_id,
  input  logic [DATA_WIDTH-1:0] data_seed,
  output payload_t              out_payload,
  output logic                  dvalid,
  input  logic                  dready,
  output logic                  busy,
  output logic                  done,
  output logic [LEN_WIDTH-1:0]  beat_cnt
);

  src_state_t           state;
  logic [LEN_WIDTH-1:0] len_q;
  logic [LEN_WIDTH-1:0] last_idx;

  assign last_idx = len_q - LEN_WIDTH'(1);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= ST_IDLE;
      out_payload <= '0;
      dvalid      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      beat_cnt    <= '0;
      len_q       <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            len_q            <= len;
            beat_cnt         <= '0;
            busy             <= 1'b1;
            out_payload.id   <= start_id;
            out_payload.addr <= base_addr;
            out_payload.data <= data_seed;
            if (len != '0) begin
              state  <= ST_SEND;
              dvalid <= 1'b1;
            end else begin
              state <= ST_DONE;
              done  <= 1'b1;
            end
          end
        end
        ST_SEND: begin
          if (dready) begin
            beat_cnt <= beat_cnt + LEN_WIDTH'(1);
            // beat_cnt still holds the index of the beat being accepted
            if (beat_cnt == last_idx) begin
              dvalid <= 1'b0;
              done   <= 1'b1;
              state  <= ST_DONE;
            end else begin
              out_payload.id   <= out_payload.id + ID_WIDTH'(1);
              out_payload.addr <= out_payload.addr + ADDR_WIDTH'(ADDR_STRIDE);
              out_payload.data <= out_payload.data + DATA_WIDTH'(1);
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_payload_src.sv
// Directed bench for payload_src: burst table plus reset and start-while-busy sequences.
module tb_payload_src;
  import payload_package::*;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic        dready = 1'b0;
  logic [31:0] base_addr = '0;
  logic [31:0] data_seed = '0;
  logic [7:0]  len = '0;
  logic [2:0]  start_id = '0;
  payload_t    out_payload;
  logic        dvalid, busy, done;
  logic [7:0]  beat_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  payload_src dut (
    .clk(clk), .rstn(rstn), .start(start), .base_addr(base_addr), .len(len),
    .start_id(start_id), .data_seed(data_seed), .out_payload(out_payload),
    .dvalid(dvalid), .dready(dready), .busy(busy), .done(done), .beat_cnt(beat_cnt)
  );

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // mode: 0 dready=1, 1 random, 2 stall beat 1 for 5 cycles then random, 3 start pulse during SEND
  typedef struct {
    logic [31:0] base;
    logic [7:0]  len;
    logic [2:0]  sid;
    logic [31:0] seed;
    int          mode;
    logic [2:0]  last_id;
    logic [31:0] last_addr;
    logic [31:0] last_data;
  } vec_t;

  vec_t vecs[6];

  task automatic run_burst(input vec_t v);
    int       n = 0;
    int       stall = 0;
    logic     got_done = 1'b0;
    logic     prev_hold = 1'b0;
    logic     rdy;
    payload_t prev_p = '0;
    payload_t last_p = '0;
    payload_t exp_p;
    @(negedge clk);
    base_addr = v.base; len = v.len; start_id = v.sid; data_seed = v.seed;
    start = 1'b1; dready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 300 && !got_done; cyc++) begin
      case (v.mode)
        0: rdy = 1'b1;
        1: rdy = 1'($urandom_range(0, 1));
        2: begin
          if (n == 1 && stall < 5) begin
            rdy = 1'b0;
            stall++;
          end else rdy = 1'($urandom_range(0, 1));
        end
        default: rdy = (cyc != 0);
      endcase
      if (v.mode == 3 && cyc == 1) begin
        start = 1'b1;
        len = 8'd7;
      end else start = 1'b0;
      dready = rdy;
      #1;
      if (prev_hold) begin
        chk("hold_valid", 80'(dvalid), 80'(1));
        chk("hold_payload", 80'(out_payload), 80'(prev_p));
      end
      if (v.len == 0) chk("zero_no_valid", 80'(dvalid), 80'(0));
      if (dvalid) begin
        exp_p.id   = v.sid + 3'(n);
        exp_p.addr = v.base + 32'(4 * n);
        exp_p.data = v.seed + 32'(n);
        chk("beat", 80'(out_payload), 80'(exp_p));
        if (rdy) begin
          n++;
          last_p = out_payload;
        end
      end
      prev_hold = dvalid && !rdy;
      prev_p = out_payload;
      if (done) begin
        got_done = 1'b1;
        chk("done_beat_cnt", 80'(beat_cnt), 80'(v.len));
        chk("done_busy", 80'(busy), 80'(1));
        chk("done_valid", 80'(dvalid), 80'(0));
        chk("transfers", 80'(n), 80'(v.len));
        if (v.len != 0)
          chk("last_beat", 80'(last_p), 80'({v.last_id, v.last_addr, v.last_data}));
        else
          chk("zero_done_latency", 80'(cyc), 80'(0));
        if (v.mode == 0) chk("burst_time", 80'(cyc), 80'(v.len));
      end
      @(negedge clk);
    end
    start = 1'b0;
    if (!got_done) chk("done_timeout", 80'(0), 80'(1));
    for (int i = 0; i < 4; i++) begin
      dready = 1'($urandom_range(0, 1));
      #1;
      chk("idle_valid", 80'(dvalid), 80'(0));
      chk("idle_done", 80'(done), 80'(0));
      chk("idle_busy", 80'(busy), 80'(0));
      if (i == 0) chk("idle_beat_cnt", 80'(beat_cnt), 80'(v.len));
      @(negedge clk);
    end
  endtask

  initial begin
    logic reached;
    vecs[0] = '{32'h1000,     8'd4,  3'd6, 32'hA0,       0, 3'd1, 32'h100C, 32'hA3};
    vecs[1] = '{32'h200,      8'd3,  3'd2, 32'h10,       2, 3'd4, 32'h208,  32'h12};
    vecs[2] = '{32'h300,      8'd0,  3'd1, 32'h5,        0, 3'd0, 32'h0,    32'h0};
    vecs[3] = '{32'hFFFFFFF8, 8'd3,  3'd5, 32'hFFFFFFFF, 3, 3'd7, 32'h0,    32'h1};
    vecs[4] = '{32'h4000,     8'd16, 3'd0, 32'h100,      1, 3'd7, 32'h403C, 32'h10F};
    vecs[5] = '{32'h20,       8'd1,  3'd7, 32'h55,       0, 3'd7, 32'h20,   32'h55};

    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", 80'(dvalid), 80'(0));
    chk("rst_busy", 80'(busy), 80'(0));
    chk("rst_done", 80'(done), 80'(0));
    chk("rst_beat_cnt", 80'(beat_cnt), 80'(0));
    chk("rst_payload", 80'(out_payload), 80'(0));
    @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < 6; i++) run_burst(vecs[i]);

    // Reset in the middle of a 5-beat burst after two transfers
    @(negedge clk);
    base_addr = 32'h8000; len = 8'd5; start_id = 3'd0; data_seed = 32'h0;
    start = 1'b1; dready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    reached = 1'b0;
    for (int c = 0; c < 20 && !reached; c++) begin
      #1;
      if (beat_cnt == 8'd2) reached = 1'b1;
      else @(negedge clk);
    end
    chk("mid_reached", 80'(reached), 80'(1));
    chk("pre_reset_valid", 80'(dvalid), 80'(1));
    #2;
    rstn = 1'b0;
    #1;
    chk("async_valid", 80'(dvalid), 80'(0));
    chk("async_busy", 80'(busy), 80'(0));
    chk("async_beat_cnt", 80'(beat_cnt), 80'(0));
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      chk("post_rst_valid", 80'(dvalid), 80'(0));
      chk("post_rst_busy", 80'(busy), 80'(0));
      chk("post_rst_done", 80'(done), 80'(0));
    end
    run_burst(vecs[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
